// File: rtl/maq_h.sv
// Hours machine: BCD hour count 00-23 advanced by minute carries in RUN,
// stepped by up/down button edges in SET, shown in 24 h or 12 h AM/PM form.
module maq_h #(
    parameter int HORA_INICIAL = 0
) (
    input  logic       maqh_clock,
    input  logic       maqh_reset,
    input  logic       maqh_enable,
    input  logic       maqh_incremento,
    input  logic       maqh_ajuste,
    input  logic       maqh_up,
    input  logic       maqh_down,
    input  logic       maqh_modo12,
    output logic [3:0] maqh_lsd,
    output logic [1:0] maqh_msd,
    output logic       maqh_pm,
    output logic       maqh_incrementadia,
    output logic       maqh_ajustando
);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    localparam logic [1:0] MSD_INI = 2'(HORA_INICIAL / 10);
    localparam logic [3:0] LSD_INI = 4'(HORA_INICIAL % 10);

    state_t     state_q, state_d;
    logic [1:0] msd_q, msd_d;
    logic [3:0] lsd_q, lsd_d;
    logic       up_q, down_q;
    logic       dia_q, dia_d;
    logic       up_edge, down_edge;
    logic       at_23;

    always_ff @(posedge maqh_clock or negedge maqh_reset) begin
        if (!maqh_reset) begin
            state_q <= RUN;
            msd_q   <= MSD_INI;
            lsd_q   <= LSD_INI;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            dia_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            msd_q   <= msd_d;
            lsd_q   <= lsd_d;
            up_q    <= maqh_up;
            down_q  <= maqh_down;
            dia_q   <= dia_d;
        end
    end

    assign up_edge   = maqh_up && !up_q;
    assign down_edge = maqh_down && !down_q;
    assign at_23     = (msd_q == 2'd2) && (lsd_q == 4'd3);

    always_comb begin
        state_d = state_q;
        msd_d   = msd_q;
        lsd_d   = lsd_q;
        dia_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (maqh_enable && maqh_incremento) begin
                    if (at_23) begin
                        msd_d = 2'd0;
                        lsd_d = 4'd0;
                        dia_d = 1'b1;
                    end else if (lsd_q == 4'd9) begin
                        msd_d = msd_q + 2'd1;
                        lsd_d = 4'd0;
                    end else begin
                        lsd_d = lsd_q + 4'd1;
                    end
                end
                if (maqh_ajuste) state_d = SET;
            end
            SET: begin
                // Simultaneous up and down edges cancel out.
                if (up_edge && !down_edge) begin
                    if (at_23) begin
                        msd_d = 2'd0;
                        lsd_d = 4'd0;
                    end else if (lsd_q == 4'd9) begin
                        msd_d = msd_q + 2'd1;
                        lsd_d = 4'd0;
                    end else begin
                        lsd_d = lsd_q + 4'd1;
                    end
                end else if (down_edge && !up_edge) begin
                    if (msd_q == 2'd0 && lsd_q == 4'd0) begin
                        msd_d = 2'd2;
                        lsd_d = 4'd3;
                    end else if (lsd_q == 4'd0) begin
                        msd_d = msd_q - 2'd1;
                        lsd_d = 4'd9;
                    end else begin
                        lsd_d = lsd_q - 4'd1;
                    end
                end
                if (!maqh_ajuste) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign maqh_incrementadia = dia_q;
    assign maqh_ajustando     = (state_q == SET);

    logic [4:0] hora_bin, hora_disp, resto;

    always_comb begin
        hora_bin  = ({3'b000, msd_q} * 5'd10) + {1'b0, lsd_q};
        hora_disp = hora_bin;
        maqh_pm   = 1'b0;
        if (maqh_modo12) begin
            maqh_pm = (hora_bin >= 5'd12);
            if (hora_bin == 5'd0)      hora_disp = 5'd12;
            else if (hora_bin > 5'd12) hora_disp = hora_bin - 5'd12;
        end
        if (hora_disp >= 5'd20) begin
            maqh_msd = 2'd2;
            resto    = hora_disp - 5'd20;
        end else if (hora_disp >= 5'd10) begin
            maqh_msd = 2'd1;
            resto    = hora_disp - 5'd10;
        end else begin
            maqh_msd = 2'd0;
            resto    = hora_disp;
        end
        maqh_lsd = resto[3:0];
    end

endmodule
